// File: rtl/matrix_chain.sv
// Daisy-chained 8x8 LED matrix driver: double-buffered frame store behind a Wishbone
// pipelined slave, serialised row by row onto a shift-clock / latch / data link.
module matrix_chain #(
   parameter int unsigned N_PANELS       = 2,
   parameter int unsigned CLK_DIV        = 4,
   parameter int unsigned DWELL_CYCLES   = 1000,
   parameter int unsigned ROW_ACTIVE_LOW = 0,
   parameter int unsigned COL_ACTIVE_LOW = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  i_refresh_speed,
   output logic        o_matrix_clk,
   output logic        o_matrix_latch,
   output logic        o_matrix_mosi,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   input  logic        i_wb_we,
   input  logic [7:0]  i_wb_addr,
   input  logic [3:0]  i_wb_sel,
   input  logic [31:0] i_wb_wdata,
   output logic        o_wb_ack,
   output logic        o_wb_stall,
   output logic [31:0] o_wb_rdata
);

   localparam int unsigned NBYTES = 8 * N_PANELS;
   localparam int unsigned SW     = 16 * N_PANELS;
   localparam int unsigned AW     = $clog2(NBYTES);
   localparam int unsigned BW     = $clog2(SW);
   localparam int unsigned DIVW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [7:0]      BankLimit = 8'(NBYTES);
   localparam logic [7:0]      CtrlAddr  = 8'h80;
   localparam logic [DIVW-1:0] DivLast   = DIVW'(CLK_DIV - 1);
   localparam logic [BW-1:0]   BitLast   = BW'(SW - 1);

   typedef enum logic [2:0] {
      StLoad,
      StShiftLo,
      StShiftHi,
      StLatch,
      StDwell
   } state_e;

   state_e            state_q, state_d;
   logic [2:0]        row_q, row_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [DIVW-1:0]   div_q, div_d;
   logic [SW-1:0]     shift_q, shift_d;
   logic [31:0]       dwell_q, dwell_d;
   logic              front_q, front_d;
   logic              pending_q, pending_d;
   logic              ack_q;
   logic [31:0]       rdata_q, rdata_d;

   logic [7:0]        bank_q [2][NBYTES];

   logic              wb_req, in_range, is_ctrl, bank_we, ctrl_we;
   logic              back_sel, frame_end, swap;
   logic [AW-1:0]     wb_idx;
   logic [SW-1:0]     load_word;
   logic [31:0]       dwell_len;
   logic              mclk, mlatch, mmosi;
   logic              unused_wb;

   // ------------------------------------------------------------------
   // Wishbone slave
   // ------------------------------------------------------------------
   assign wb_req    = i_wb_cyc & i_wb_stb;
   assign in_range  = i_wb_addr < BankLimit;
   assign is_ctrl   = i_wb_addr == CtrlAddr;
   assign wb_idx    = i_wb_addr[AW-1:0];
   assign back_sel  = ~front_q;
   assign bank_we   = wb_req & i_wb_we & in_range & i_wb_sel[0];
   assign ctrl_we   = wb_req & i_wb_we & is_ctrl & i_wb_sel[0] & i_wb_wdata[0];
   assign unused_wb = ^{i_wb_sel[3:1], i_wb_wdata[31:8]};

   always_comb begin
      rdata_d = '0;
      if (wb_req && !i_wb_we) begin
         if (in_range) begin
            rdata_d = {24'b0, bank_q[back_sel][wb_idx]};
         end else if (is_ctrl) begin
            rdata_d = {31'b0, pending_q};
         end
      end
   end

   // Swap happens on the DWELL exit of row 7; a control write in that same cycle wins.
   assign frame_end = (state_q == StDwell) && (dwell_q == 32'd0) && (row_q == 3'd7);
   assign swap      = frame_end & pending_q;
   assign front_d   = front_q ^ swap;

   always_comb begin
      pending_d = pending_q;
      if (ctrl_we) begin
         pending_d = 1'b1;
      end else if (swap) begin
         pending_d = 1'b0;
      end
   end

   // Writes use the back index from before any same-cycle swap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NBYTES; i++) begin
               bank_q[b][i] <= 8'h00;
            end
         end
      end else if (bank_we) begin
         bank_q[back_sel][wb_idx] <= i_wb_wdata[7:0];
      end
   end

   // ------------------------------------------------------------------
   // Shift word: farthest panel in the top bits so it leaves first
   // ------------------------------------------------------------------
   always_comb begin
      logic [7:0]    row_byte;
      logic [7:0]    col_byte;
      logic [AW-1:0] idx;
      load_word = '0;
      row_byte  = '0;
      col_byte  = '0;
      idx       = '0;
      for (int p = 0; p < N_PANELS; p++) begin
         idx      = AW'(p * 8 + int'(row_q));
         row_byte = 8'b1 << row_q;
         col_byte = bank_q[front_q][idx];
         if (ROW_ACTIVE_LOW != 0) begin
            row_byte = ~row_byte;
         end
         if (COL_ACTIVE_LOW != 0) begin
            col_byte = ~col_byte;
         end
         load_word[p*16 +: 16] = {row_byte, col_byte};
      end
   end

   assign dwell_len = 32'(DWELL_CYCLES) << i_refresh_speed;

   // ------------------------------------------------------------------
   // Display FSM
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      bit_d   = bit_q;
      div_d   = div_q;
      shift_d = shift_q;
      dwell_d = dwell_q;
      mclk    = 1'b0;
      mlatch  = 1'b0;
      mmosi   = 1'b0;
      unique case (state_q)
         StLoad: begin
            shift_d = load_word;
            bit_d   = '0;
            div_d   = '0;
            state_d = StShiftLo;
         end
         StShiftLo: begin
            mmosi = shift_q[SW-1];
            if (div_q == DivLast) begin
               div_d   = '0;
               state_d = StShiftHi;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         StShiftHi: begin
            mclk  = 1'b1;
            mmosi = shift_q[SW-1];
            if (div_q == DivLast) begin
               div_d = '0;
               if (bit_q == BitLast) begin
                  state_d = StLatch;
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shift_d = shift_q << 1;
                  state_d = StShiftLo;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         StLatch: begin
            mlatch = 1'b1;
            if (div_q == DivLast) begin
               div_d   = '0;
               dwell_d = dwell_len - 32'd1;
               state_d = StDwell;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         StDwell: begin
            if (dwell_q == 32'd0) begin
               row_d   = row_q + 1'b1;
               state_d = StLoad;
            end else begin
               dwell_d = dwell_q - 32'd1;
            end
         end
         default: begin
            state_d = StLoad;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StLoad;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_q     <= '0;
         bit_q     <= '0;
         div_q     <= '0;
         shift_q   <= '0;
         dwell_q   <= '0;
         front_q   <= 1'b0;
         pending_q <= 1'b0;
         ack_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         row_q     <= row_d;
         bit_q     <= bit_d;
         div_q     <= div_d;
         shift_q   <= shift_d;
         dwell_q   <= dwell_d;
         front_q   <= front_d;
         pending_q <= pending_d;
         ack_q     <= wb_req;
         rdata_q   <= rdata_d;
      end
   end

   // Link outputs decode straight from the state, so reset drops them asynchronously.
   assign o_matrix_clk   = mclk;
   assign o_matrix_latch = mlatch;
   assign o_matrix_mosi  = mmosi;
   assign o_wb_ack       = ack_q;
   assign o_wb_stall     = 1'b0;
   assign o_wb_rdata     = rdata_q;

endmodule

// File: tb/tb_matrix_chain.sv
// Directed bench: a 2-panel non-inverted chain and a 1-panel fully inverted chain share one bus.
module tb_matrix_chain;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  speed = 2'd0;
   logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
   logic [7:0]  wb_addr = '0;
   logic [3:0]  wb_sel = '0;
   logic [31:0] wb_wdata = '0;

   logic [1:0]  mclk, mlat, mmosi, ack, stall;
   logic [31:0] rdata0, rdata1;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   matrix_chain #(
      .N_PANELS(2), .CLK_DIV(1), .DWELL_CYCLES(10), .ROW_ACTIVE_LOW(0), .COL_ACTIVE_LOW(0)
   ) dut (
      .clk(clk), .reset(reset), .i_refresh_speed(speed),
      .o_matrix_clk(mclk[0]), .o_matrix_latch(mlat[0]), .o_matrix_mosi(mmosi[0]),
      .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we), .i_wb_addr(wb_addr),
      .i_wb_sel(wb_sel), .i_wb_wdata(wb_wdata),
      .o_wb_ack(ack[0]), .o_wb_stall(stall[0]), .o_wb_rdata(rdata0)
   );

   matrix_chain #(
      .N_PANELS(1), .CLK_DIV(2), .DWELL_CYCLES(10), .ROW_ACTIVE_LOW(1), .COL_ACTIVE_LOW(1)
   ) dut_inv (
      .clk(clk), .reset(reset), .i_refresh_speed(speed),
      .o_matrix_clk(mclk[1]), .o_matrix_latch(mlat[1]), .o_matrix_mosi(mmosi[1]),
      .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we), .i_wb_addr(wb_addr),
      .i_wb_sel(wb_sel), .i_wb_wdata(wb_wdata),
      .o_wb_ack(ack[1]), .o_wb_stall(stall[1]), .o_wb_rdata(rdata1)
   );

   // Link monitor: collects each latched word, its latch length and the idle gap before it.
   int          cyc_n = 0;
   logic [31:0] acc [2];
   int          nw [2];
   int          lcnt [2];
   int          fall_at [2];
   logic        gap_pend [2];
   logic        pclk [2];
   logic        plat [2];
   logic [31:0] words [2][32];
   int          llen [2][32];
   int          gap [2][32];

   always @(negedge clk) begin
      cyc_n <= cyc_n + 1;
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            acc[d]      <= '0;
            nw[d]       <= 0;
            lcnt[d]     <= 0;
            gap_pend[d] <= 1'b0;
            pclk[d]     <= 1'b0;
            plat[d]     <= 1'b0;
         end else begin
            pclk[d] <= mclk[d];
            plat[d] <= mlat[d];
            if (mclk[d] && !pclk[d]) begin
               acc[d] <= {acc[d][30:0], mmosi[d]};
               if (gap_pend[d] && nw[d] < 32) begin
                  gap[d][nw[d]] <= cyc_n - fall_at[d];
                  gap_pend[d]   <= 1'b0;
               end
            end
            if (mlat[d]) lcnt[d] <= lcnt[d] + 1;
            if (!mlat[d] && plat[d]) begin
               if (nw[d] < 32) begin
                  words[d][nw[d]] <= acc[d];
                  llen[d][nw[d]]  <= lcnt[d];
               end
               nw[d]       <= nw[d] + 1;
               lcnt[d]     <= 0;
               acc[d]      <= '0;
               fall_at[d]  <= cyc_n;
               gap_pend[d] <= 1'b1;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_words(input int d, input int n, input string tag);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (nw[d] >= n) begin
            ok = 1'b1;
            break;
         end
      end
      chk(tag, 32'(ok), 32'd1);
   endtask

   task automatic wb(input logic we, input logic [7:0] addr, input logic [3:0] sel,
                     input logic [31:0] wd, input string tag, output logic [31:0] rd);
      @(negedge clk);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
      wb_addr = addr; wb_sel = sel; wb_wdata = wd;
      @(negedge clk);
      chk({tag, "_ack"}, 32'(ack[0]), 32'd1);
      rd = rdata0;
      if (we) chk({tag, "_wrdata"}, rdata0, 32'd0);
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      @(negedge clk);
      chk({tag, "_ackdrop"}, {31'b0, ack[0]}, 32'd0);
      chk({tag, "_rdclr"}, rdata0, 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      logic        ok;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_outs", {27'b0, mclk[0], mlat[0], mmosi[0], ack[0], stall[0]}, 32'd0);
      chk("rst_rdata", rdata0, 32'd0);
      chk("rst_inv_outs", {29'b0, mclk[1], mlat[1], mmosi[1]}, 32'd0);
      reset = 1'b0;

      // Fill back bank, probe ignored writes and unmapped reads
      wb(1'b1, 8'd8, 4'b0001, 32'h0000_000F, "wr_p1r0", rd);
      wb(1'b1, 8'd0, 4'b0001, 32'h0000_00F0, "wr_p0r0", rd);
      wb(1'b1, 8'd1, 4'b1110, 32'h0000_0055, "wr_nosel", rd);
      wb(1'b0, 8'd1, 4'b1111, 32'h0, "rd_nosel", rd);
      chk("rd_nosel_val", rd, 32'd0);
      wb(1'b0, 8'd8, 4'b1111, 32'h0, "rd_p1r0", rd);
      chk("rd_p1r0_val", rd, 32'h0000_000F);
      wb(1'b1, 8'h40, 4'b0001, 32'h0000_00AA, "wr_0x40", rd);
      wb(1'b0, 8'h40, 4'b1111, 32'h0, "rd_0x40", rd);
      chk("rd_0x40_val", rd, 32'd0);
      wb(1'b0, 8'h80, 4'b1111, 32'h0, "rd_ctrl0", rd);
      chk("rd_ctrl0_val", rd, 32'd0);

      // Request swap mid-frame
      wb(1'b1, 8'h80, 4'b0001, 32'h1, "wr_ctrl", rd);
      wb(1'b0, 8'h80, 4'b1111, 32'h0, "rd_ctrl1", rd);
      chk("rd_ctrl1_val", rd, 32'd1);

      wait_words(0, 7, "tmo_w7");
      wb(1'b0, 8'h80, 4'b1111, 32'h0, "rd_ctrl_r7", rd);
      chk("rd_ctrl_r7_val", rd, 32'd1);
      chk("w0_cleared", words[0][0], 32'h0100_0100);
      chk("w3_cleared", words[0][3], 32'h0800_0800);
      chk("latch_len", 32'(llen[0][0]), 32'd1);
      chk("gap_speed0", 32'(gap[0][1]), 32'd12);

      wait_words(0, 9, "tmo_w9");
      chk("w7_preswap", words[0][7], 32'h8000_8000);
      chk("w8_swapped", words[0][8], 32'h010F_01F0);
      wb(1'b0, 8'h80, 4'b1111, 32'h0, "rd_ctrl_post", rd);
      chk("rd_ctrl_post_val", rd, 32'd0);
      wb(1'b0, 8'd8, 4'b1111, 32'h0, "rd_newback", rd);
      chk("rd_newback_val", rd, 32'd0);

      // Dwell multiplier: 10 << 3 = 80 dwell cycles, plus LOAD and SHIFT_LO
      speed = 2'd3;
      wait_words(0, 11, "tmo_w11");
      speed = 2'd0;
      chk("gap_w9", 32'(gap[0][9]), 32'd12);
      chk("gap_w10", 32'(gap[0][10]), 32'd82);
      chk("w9_row1", words[0][9], 32'h0200_0200);

      // Asynchronous reset while the shift clock is high
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (mclk[0]) begin
            ok = 1'b1;
            break;
         end
      end
      chk("tmo_shifthi", 32'(ok), 32'd1);
      #1 reset = 1'b1;
      #1 chk("async_clk_low", {30'b0, mclk[0], mlat[0]}, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;

      wait_words(0, 1, "tmo_rst_w0");
      chk("rst_w0_cleared", words[0][0], 32'h0100_0100);

      // Inverted single-panel chain
      wait_words(1, 4, "tmo_inv_w3");
      chk("inv_w0", words[1][0], 32'h0000_FEFF);
      chk("inv_w3", words[1][3], 32'h0000_F7FF);
      chk("inv_latch_len", 32'(llen[1][0]), 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/matrix_chain.md
MATRIX_CHAIN -- requirements
Module: matrix_chain

Interface
REQ-001 Parameter N_PANELS, default 2: number of daisy-chained 8x8 panels, legal range 1..8.
REQ-002 Parameter CLK_DIV, default 4: number of clk cycles per shift-clock half period, minimum 1.
REQ-003 Parameter DWELL_CYCLES, default 1000: base row-display time in clk cycles.
REQ-004 Parameter ROW_ACTIVE_LOW, default 0: when 1, the row byte is inverted before shifting.
REQ-005 Parameter COL_ACTIVE_LOW, default 0: when 1, the column byte is inverted before shifting.
REQ-006 clk  in  1  single system clock; all logic is on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 i_refresh_speed  in  2  dwell multiplier select.
REQ-009 o_matrix_clk, o_matrix_latch, o_matrix_mosi  out  1 each  shift clock, output latch, shift data.
REQ-010 i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  Wishbone pipelined cycle, strobe and write enable.
REQ-011 i_wb_addr  in  8  word address; i_wb_sel  in  4  byte select; i_wb_wdata  in  32  write data.
REQ-012 o_wb_ack, o_wb_stall  out  1 each; o_wb_rdata  out  32  read data.

Function
REQ-013 Two frame banks of 8*N_PANELS bytes: front (displayed) and back (bus-visible); word p*8+r holds panel p, row r, with bit c = column c.
REQ-014 A request is accepted when i_wb_cyc and i_wb_stb are both high; o_wb_stall is constant 0; o_wb_ack goes high exactly one cycle after acceptance, for one cycle.
REQ-015 Addresses below 8*N_PANELS: a write with i_wb_sel[0]=1 stores wdata[7:0] into the back bank; a read returns {24'b0, back byte}.
REQ-016 Address 0x80 (control): a write with wdata[0]=1 and sel[0]=1 sets swap_pending; a read returns {31'b0, swap_pending}.
REQ-017 All other addresses: writes are ignored; reads return 0; ack is still generated.
REQ-018 o_wb_rdata is registered and valid in the ack cycle; it is 0 in all other cycles.
REQ-019 FSM states: LOAD, SHIFT_LO, SHIFT_HI, LATCH, DWELL.
REQ-020 LOAD (1 cycle): build a 16*N_PANELS-bit shift word for the current row r from the front bank; the farthest panel (N_PANELS-1) is first; each panel contributes row byte (1<<r, optionally inverted) then column byte (optionally inverted); MSB is first.
REQ-021 SHIFT_LO: o_matrix_clk=0 and o_matrix_mosi=current bit for CLK_DIV cycles, then go to SHIFT_HI.
REQ-022 SHIFT_HI: o_matrix_clk=1 for CLK_DIV cycles with mosi held; then advance the bit, returning to SHIFT_LO, or go to LATCH after bit 16*N_PANELS-1.
REQ-023 LATCH: o_matrix_latch=1 for CLK_DIV cycles, clk=0, mosi=0; then go to DWELL.
REQ-024 DWELL: all outputs 0 for DWELL_CYCLES << i_refresh_speed cycles, with speed sampled on DWELL entry; then r increments (7 wraps to 0) and the FSM goes to LOAD.
REQ-025 Frame boundary is the DWELL exit with r=7: if swap_pending, exchange front/back bank roles and clear swap_pending in that cycle.
REQ-026 A control write in the same cycle as a swap re-sets swap_pending, and it applies at the next frame boundary.
REQ-027 A back-bank write in the swap cycle targets the pre-swap back bank.
REQ-028 A swap request mid-frame never alters the row currently being shifted or displayed.

Reset
REQ-029 While reset is high, the FSM is in LOAD with r=0, and o_matrix_clk, o_matrix_latch, o_matrix_mosi, o_wb_ack and o_wb_rdata are all 0.
REQ-030 Reset also clears both banks to 0, sets bank 0 as front, and clears swap_pending.
REQ-031 Reset asserted mid-shift or mid-latch forces the outputs low asynchronously; after release, shifting restarts at row 0, bit 0.

Verification
REQ-032 N_PANELS=1, CLK_DIV=1, front byte row0=0xA5 -> 16 clk rising edges carrying mosi 0x01 then 0xA5 MSB first, then one latch pulse of 1 cycle.
REQ-033 N_PANELS=2: back p1r0=0x0F and p0r0=0xF0, then swap -> after the frame boundary, row 0 shifts 0x01,0x0F,0x01,0xF0.
REQ-034 Write control=1 mid-frame -> read 0x80 returns 1 until the r=7 DWELL exit; the display is unchanged until then, and the read returns 0 afterwards.
REQ-035 i_refresh_speed=3, DWELL_CYCLES=10 -> 80 cycles between the latch falling and the next LOAD; ack arrives 1 cycle after each stb, and reads of address 0x40 with N_PANELS=2 return 0.
REQ-036 Reset pulse during SHIFT_HI -> o_matrix_clk falls the same cycle; after release, the first shifted word is row 0 of a cleared bank (0x01,0x00 per panel).
REQ-037 COL_ACTIVE_LOW=1, ROW_ACTIVE_LOW=1, row3 byte=0x00 -> the row3 shift word is 0xF7,0xFF per panel.
